// File: rtl/fifo_stream_reader_if.sv
// FIFO read-port and output-stream bundle for fifo_stream_reader.
// master = the reader (drives pops and the stream), slave = FIFO plus downstream sink.
interface fifo_stream_reader_if #(
    parameter int BITS = 32
);
    logic            fifo_rd_en;
    logic [BITS-1:0] fifo_rd_data;
    logic            fifo_rd_empty;
    logic            m_valid;
    logic            m_ready;
    logic [BITS-1:0] m_data;
    logic            m_last;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_rd_empty,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_rd_empty,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-domain drain engine: pops the async FIFO into a 3-deep in-order buffer and
// presents the words as a framed valid/ready stream at one word per clock.
module fifo_stream_reader #(
    parameter int BITS     = 32,
    parameter int PKT_LEN  = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic                enable,
    fifo_stream_reader_if.master bus,
    output logic [CNT_BITS-1:0] word_count
);
    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic [BITS-1:0]   mem [3];
    logic [1:0]        occ;
    logic              inflight;
    logic [BEAT_W-1:0] beat;
    logic [2:0]        pending;
    logic              rd_en;
    logic              valid;
    logic              hs;
    logic [1:0]        wr_idx;

    // Committed words (buffered plus in flight) must leave a free slot for the next capture.
    assign pending = {1'b0, occ} + {2'b0, inflight};
    assign rd_en   = enable & ~bus.fifo_rd_empty & (pending <= 3'd2) & ~rd_rst;
    assign valid   = (occ != 2'd0);
    assign hs      = valid & bus.m_ready;
    assign wr_idx  = occ - {1'b0, hs};

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid;
    assign bus.m_data     = mem[0];
    assign bus.m_last     = valid & (beat == LAST_BEAT);

    // mem[0] is the head; a handshake shifts down while a capture lands just past the survivors.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
            occ        <= 2'd0;
            inflight   <= 1'b0;
            beat       <= '0;
            word_count <= '0;
        end else begin
            inflight <= rd_en;
            occ      <= occ + {1'b0, inflight} - {1'b0, hs};
            if (hs) begin
                mem[0] <= mem[1];
                mem[1] <= mem[2];
            end
            for (int i = 0; i < 3; i++) begin
                if (inflight && (wr_idx == 2'(i))) begin
                    mem[i] <= bus.fifo_rd_data;
                end
            end
            if (hs) begin
                word_count <= word_count + CNT_BITS'(1);
                beat       <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: three reader instances (PKT_LEN 4/3/1) share one FIFO model and
// are compared against a word-queue reference model plus directed vector tables.
module tb_fifo_stream_reader;
    localparam int BITS = 32;

    logic            rd_clk = 1'b0;
    logic            rd_rst;
    logic            enable;
    logic            m_ready;
    logic            fifo_rd_empty;
    logic [BITS-1:0] fifo_rd_data;
    logic [15:0]     wc4;
    logic [3:0]      wc3;
    logic [3:0]      wc1;

    fifo_stream_reader_if #(.BITS(BITS)) if4 ();
    fifo_stream_reader_if #(.BITS(BITS)) if3 ();
    fifo_stream_reader_if #(.BITS(BITS)) if1 ();

    assign if4.fifo_rd_data  = fifo_rd_data;
    assign if4.fifo_rd_empty = fifo_rd_empty;
    assign if4.m_ready       = m_ready;
    assign if3.fifo_rd_data  = fifo_rd_data;
    assign if3.fifo_rd_empty = fifo_rd_empty;
    assign if3.m_ready       = m_ready;
    assign if1.fifo_rd_data  = fifo_rd_data;
    assign if1.fifo_rd_empty = fifo_rd_empty;
    assign if1.m_ready       = m_ready;

    fifo_stream_reader #(.BITS(BITS), .PKT_LEN(4), .CNT_BITS(16)) dut4 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .bus(if4.master), .word_count(wc4));
    fifo_stream_reader #(.BITS(BITS), .PKT_LEN(3), .CNT_BITS(4)) dut3 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .bus(if3.master), .word_count(wc3));
    fifo_stream_reader #(.BITS(BITS), .PKT_LEN(1), .CNT_BITS(4)) dut1 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .bus(if1.master), .word_count(wc1));

    always #5 rd_clk = ~rd_clk;

    typedef struct packed {
        bit en;
        bit rdy;
        bit expRdEn;
        bit expValid;
    } vec_t;

    // Reference model: words still in the FIFO, and words popped but not yet accepted.
    logic [BITS-1:0] fifoQ[$];
    logic [BITS-1:0] outQ[$];
    logic [BITS-1:0] pendingData;
    int              accepted;
    int              totalAccepted;
    int              pops;
    int              errors;
    int              checks;
    bit              poppedLast;
    bit              sRdEn;
    bit              sValid;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic loadWords(input int n);
        repeat (n) fifoQ.push_back($urandom);
    endtask

    task automatic applyStimulus(input bit en, input bit rdy, input bit gp);
        bit expRdEn;
        bit expValid;
        bit pop;
        bit hs;
        int held;
        @(negedge rd_clk);
        enable        = en;
        m_ready       = rdy;
        fifo_rd_empty = gp || (fifoQ.size() == 0);
        #1;
        held     = outQ.size() - (poppedLast ? 1 : 0);
        expRdEn  = en && !fifo_rd_empty && (outQ.size() <= 2);
        expValid = held > 0;
        sRdEn    = if4.fifo_rd_en;
        sValid   = if4.m_valid;
        checkOutput("fifo_rd_en", 32'({if4.fifo_rd_en, if3.fifo_rd_en, if1.fifo_rd_en}), 32'({3{expRdEn}}));
        checkOutput("m_valid", 32'({if4.m_valid, if3.m_valid, if1.m_valid}), 32'({3{expValid}}));
        if (expValid) begin
            checkOutput("m_data4", if4.m_data, outQ[0]);
            checkOutput("m_data3", if3.m_data, outQ[0]);
            checkOutput("m_data1", if1.m_data, outQ[0]);
            checkOutput("m_last", 32'({if4.m_last, if3.m_last, if1.m_last}),
                        32'({accepted % 4 == 3, accepted % 3 == 2, 1'b1}));
        end
        checkOutput("word_count", 32'({wc4, wc3, wc1}), 32'({16'(accepted), 4'(accepted), 4'(accepted)}));
        pop = if4.fifo_rd_en && !fifo_rd_empty;
        hs  = expValid && rdy;
        @(posedge rd_clk);
        if (hs) begin
            void'(outQ.pop_front());
            accepted++;
            totalAccepted++;
        end
        if (pop) begin
            pendingData = fifoQ.pop_front();
            outQ.push_back(pendingData);
            pops++;
        end else begin
            pendingData = $urandom;
        end
        poppedLast = pop;
        #1 fifo_rd_data = pendingData;
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, "_rd_en"}, 32'({if4.fifo_rd_en, if3.fifo_rd_en, if1.fifo_rd_en}), 32'(0));
        checkOutput({name, "_valid_last"}, 32'({if4.m_valid, if3.m_valid, if1.m_valid,
                                                if4.m_last, if3.m_last, if1.m_last}), 32'(0));
        checkOutput({name, "_data"}, if4.m_data | if3.m_data | if1.m_data, 32'(0));
        checkOutput({name, "_count"}, 32'({wc4, wc3, wc1}), 32'(0));
    endtask

    // Reset lands mid-cycle so its effect is seen asynchronously, before any clock edge.
    task automatic pulseReset();
        @(negedge rd_clk);
        #2 rd_rst = 1'b1;
        #1 checkResetState("async_reset");
        outQ.delete();
        accepted   = 0;
        poppedLast = 1'b0;
        enable     = 1'b0;
        @(posedge rd_clk);
        @(negedge rd_clk);
        rd_rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [24];
        int   firstEn;
        int   firstV;
        int   popsBefore;
        int   target;
        int   pushed;
        int   cyc;

        for (int i = 0; i < 24; i++) begin
            vecs[i].en       = 1'b1;
            vecs[i].rdy      = (i >= 20);
            vecs[i].expRdEn  = (i < 3) || (i >= 21);
            vecs[i].expValid = (i >= 2);
        end

        rd_rst        = 1'b1;
        enable        = 1'b0;
        m_ready       = 1'b0;
        fifo_rd_empty = 1'b1;
        fifo_rd_data  = '0;
        pendingData   = '0;
        accepted      = 0;
        totalAccepted = 0;
        pops          = 0;
        errors        = 0;
        checks        = 0;
        poppedLast    = 1'b0;
        fifo_rd_empty = 1'b0;
        #12 checkResetState("reset");
        fifo_rd_empty = 1'b1;
        @(negedge rd_clk);
        rd_rst = 1'b0;

        // Eight words streamed with the sink always ready.
        loadWords(8);
        firstEn = -1;
        firstV  = -1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            if (firstEn < 0 && sRdEn) firstEn = i;
            if (firstV < 0 && sValid) firstV = i;
        end
        checkOutput("first_latency", 32'(firstV - firstEn), 32'(2));
        checkOutput("count_after_8", 32'(wc4), 32'(8));

        // Twenty cycles of backpressure from empty, then release.
        loadWords(10);
        popsBefore = pops;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].en, vecs[i].rdy, 1'b0);
            checkOutput("vec_rd_en", 32'(sRdEn), 32'(vecs[i].expRdEn));
            checkOutput("vec_valid", 32'(sValid), 32'(vecs[i].expValid));
            if (i == 19) checkOutput("stall_pops", 32'(pops - popsBefore), 32'(3));
        end
        repeat (16) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("count_after_stall", 32'(wc4), 32'(18));

        // Enable dropped with two words committed; frame resumes at beat 2.
        pulseReset();
        loadWords(10);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        popsBefore = pops;
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("paused_pops", 32'(pops - popsBefore), 32'(0));
        checkOutput("paused_count", 32'(wc4), 32'(2));
        repeat (12) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("resume_count", 32'(wc4), 32'(10));

        // Reset with two buffered words and one in flight; those three are lost.
        loadWords(10);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        pulseReset();
        repeat (12) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("count_after_reset", 32'(wc4), 32'(7));

        // Seventeen handshakes wrap the 4-bit counters to 1.
        pulseReset();
        loadWords(17);
        repeat (22) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("wrap_count3", 32'(wc3), 32'(1));
        checkOutput("wrap_count1", 32'(wc1), 32'(1));
        checkOutput("count17", 32'(wc4), 32'(17));

        // Random ready, enable, empty gaps and FIFO refill over 1000 words.
        pulseReset();
        target = totalAccepted + 1000;
        pushed = 0;
        cyc    = 0;
        while (totalAccepted < target && cyc < 20000) begin
            if (pushed < 1000 && $urandom_range(3) != 0) begin
                loadWords(1);
                pushed++;
            end
            applyStimulus($urandom_range(9) != 0, $urandom_range(1) == 1, $urandom_range(4) == 0);
            cyc++;
        end
        checkOutput("random_words", 32'(totalAccepted - (target - 1000)), 32'(1000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
